// File: rtl/cpu_pkg.sv
// Shared CPU definitions: fetch FSM states, PC redirect-source encodings,
// the IF/ID register payload and instruction field positions.
package cpu_pkg;

    // Fetch-stage FSM states.
    typedef enum logic [1:0] {
        ST_IDLE = 2'b00,
        ST_RUN  = 2'b01,
        ST_HALT = 2'b10
    } fetch_state_e;

    // Redirect source encodings for pc_sel.
    localparam logic [1:0] PCSEL_SEQ = 2'b00;
    localparam logic [1:0] PCSEL_RS  = 2'b01;
    localparam logic [1:0] PCSEL_MEM = 2'b10;

    // Instruction field positions.
    localparam int OPCODE_MSB = 31;
    localparam int OPCODE_LSB = 28;
    localparam int RD_MSB     = 27;
    localparam int RD_LSB     = 22;
    localparam int RS_MSB     = 21;
    localparam int RS_LSB     = 16;
    localparam int RT_MSB     = 15;
    localparam int RT_LSB     = 10;

    // Contents of the IF/ID pipeline register.
    typedef struct packed {
        logic [31:0] pc;
        logic [31:0] inst;
        logic        valid;
    } if_id_t;

    // Only 01 and 10 name a real target; 00 and 11 mean "no redirect".
    function automatic logic is_redirect_sel(input logic [1:0] sel);
        return (sel == PCSEL_RS) || (sel == PCSEL_MEM);
    endfunction

endpackage

// File: rtl/if_id_reg.sv
// IF/ID pipeline register.
// Ports:
//   clk, rst            - clock, asynchronous active-high reset
//   en                  - load pc_in/inst_in as a valid instruction
//   bubble              - load an empty slot (pc, inst, valid all zero)
//   pc_in, inst_in      - fetched PC and instruction word
//   pc_out, inst_out    - held PC and instruction
//   valid_out           - held slot carries a real instruction
// bubble wins over en; with neither asserted the contents are held.
module if_id_reg
    import cpu_pkg::*;
(
    input  logic        clk,
    input  logic        rst,
    input  logic        en,
    input  logic        bubble,
    input  logic [31:0] pc_in,
    input  logic [31:0] inst_in,
    output logic [31:0] pc_out,
    output logic [31:0] inst_out,
    output logic        valid_out
);

    if_id_t ifid_d;
    if_id_t ifid_q;

    always_comb begin
        // NOTE: default assignment first so every path drives ifid_d and no latch is inferred.
        ifid_d = ifid_q;
        if (bubble) begin
            ifid_d = '0;
        end else if (en) begin
            ifid_d.pc    = pc_in;
            ifid_d.inst  = inst_in;
            ifid_d.valid = 1'b1;
        end
    end

    // NOTE: sequential state uses non-blocking assignments so all flops update together at the edge.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            ifid_q <= '0;
        end else begin
            ifid_q <= ifid_d;
        end
    end

    assign pc_out    = ifid_q.pc;
    assign inst_out  = ifid_q.inst;
    assign valid_out = ifid_q.valid;

endmodule

// File: rtl/fetch_stage.sv
// Instruction fetch stage: PC register, IDLE/RUN/HALT control FSM and the
// IF/ID pipeline register.
// Ports:
//   clk, rst             - clock, asynchronous active-high reset
//   stall                - hold PC and IF/ID (hazard)
//   pc_change, pc_sel    - redirect request and its source (01 rs, 10 mem)
//   tgt_rs, tgt_mem      - redirect targets
//   halt_req             - stop fetching until reset
//   imem_addr, imem_data - instruction memory port (combinational read)
//   if_id_pc/inst/valid  - IF/ID register outputs
//   flush_idex           - squash the younger instruction in ID/EX
//   halted               - FSM is in HALT
//   fetch_count          - instructions written into IF/ID as valid
// Priority in RUN: redirect > halt > stall > sequential fetch.
module fetch_stage
    import cpu_pkg::*;
#(
    parameter logic [31:0] RESET_PC = 32'h0000_0000,
    parameter logic [31:0] PC_STEP  = 32'd1
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        stall,
    input  logic        pc_change,
    input  logic [1:0]  pc_sel,
    input  logic [31:0] tgt_rs,
    input  logic [31:0] tgt_mem,
    input  logic        halt_req,
    output logic [31:0] imem_addr,
    input  logic [31:0] imem_data,
    output logic [31:0] if_id_pc,
    output logic [31:0] if_id_inst,
    output logic        if_id_valid,
    output logic        flush_idex,
    output logic        halted,
    output logic [31:0] fetch_count
);

    fetch_state_e state_d, state_q;
    logic [31:0]  pc_d, pc_q;
    logic [31:0]  count_d, count_q;
    logic         ifid_en;
    logic         ifid_bubble;
    logic         redirect;

    // A redirect only counts while running and with a real target source.
    assign redirect = pc_change && is_redirect_sel(pc_sel) && (state_q == ST_RUN);

    always_comb begin
        state_d     = state_q;
        pc_d        = pc_q;
        count_d     = count_q;
        ifid_en     = 1'b0;
        ifid_bubble = 1'b0;
        unique case (state_q)
            ST_IDLE: begin
                state_d = ST_RUN;
            end
            ST_RUN: begin
                if (redirect) begin
                    // halt_req waits: HALT is entered on a later cycle if it persists.
                    pc_d        = (pc_sel == PCSEL_RS) ? tgt_rs : tgt_mem;
                    ifid_bubble = 1'b1;
                end else if (halt_req) begin
                    state_d     = ST_HALT;
                    ifid_bubble = 1'b1;
                end else if (!stall) begin
                    ifid_en = 1'b1;
                    pc_d    = pc_q + PC_STEP;   // wraps modulo 2^32
                    count_d = count_q + 32'd1;
                end
            end
            ST_HALT: begin
                ifid_bubble = 1'b1;
            end
            default: begin
                state_d = ST_IDLE;
            end
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q <= ST_IDLE;
            pc_q    <= RESET_PC;
            count_q <= '0;
        end else begin
            state_q <= state_d;
            pc_q    <= pc_d;
            count_q <= count_d;
        end
    end

    if_id_reg u_if_id_reg (
        .clk       (clk),
        .rst       (rst),
        .en        (ifid_en),
        .bubble    (ifid_bubble),
        .pc_in     (pc_q),
        .inst_in   (imem_data),
        .pc_out    (if_id_pc),
        .inst_out  (if_id_inst),
        .valid_out (if_id_valid)
    );

    assign imem_addr   = pc_q;
    assign flush_idex  = redirect && !rst;
    assign halted      = (state_q == ST_HALT);
    assign fetch_count = count_q;

endmodule

// File: doc/fetch_stage.md
FETCH_STAGE -- requirements
Module: fetch_stage

Interface
REQ-001 Parameter RESET_PC, default 32'h0000_0000, PC value loaded on reset.
REQ-002 Parameter PC_STEP, default 1, sequential PC increment (word addressing).
REQ-003 clk  input  1  single clock; all state updates on rising edge.
REQ-004 rst  input  1  asynchronous, active-high reset.
REQ-005 stall  input  1  hazard hold: freeze PC and IF/ID register.
REQ-006 pc_change  input  1  redirect request resolved in EX/MEM (jump, or Z/N branch taken).
REQ-007 pc_sel  input  2  redirect source: 01 = tgt_rs, 10 = tgt_mem; 00/11 treated as no redirect.
REQ-008 tgt_rs  input  32  register-sourced target (jump / branch).
REQ-009 tgt_mem  input  32  data-memory-sourced target (jump_mem).
REQ-010 halt_req  input  1  stop fetching until reset.
REQ-011 imem_addr  output  32  instruction memory address; equals current PC.
REQ-012 imem_data  input  32  instruction word; combinational read of imem_addr.
REQ-013 if_id_pc  output  32  PC of instruction held in IF/ID.
REQ-014 if_id_inst  output  32  instruction held in IF/ID.
REQ-015 if_id_valid  output  1  IF/ID holds a real instruction; 0 = bubble.
REQ-016 flush_idex  output  1  combinational; squash younger instruction in ID/EX.
REQ-017 halted  output  1  high while in HALT.
REQ-018 fetch_count  output  32  number of instructions written into IF/ID valid.

Function
REQ-019 States: IDLE, RUN, HALT; the block SHALL encode them as a 2-bit enum.
REQ-020 IDLE: no fetch, if_id_valid = 0; SHALL move to RUN unconditionally after one cycle.
REQ-021 RUN, no stall, no redirect: IF/ID <= {PC, imem_data, valid=1}; PC <= PC + PC_STEP; fetch_count += 1.
REQ-022 PC and fetch_count SHALL wrap modulo 2^32 (32'hFFFF_FFFF + 1 = 0).
REQ-023 RUN, stall = 1, pc_change = 0: PC, IF/ID contents, fetch_count held unchanged.
REQ-024 RUN, pc_change = 1 with pc_sel 01/10: PC <= selected target; if_id_valid <= 0; if_id_inst <= 0; fetch_count unchanged.
REQ-025 flush_idex SHALL equal pc_change AND (pc_sel is 01 or 10) AND state == RUN, same cycle.
REQ-026 pc_change overrides stall in the same cycle.
REQ-027 pc_change with pc_sel 00/11 SHALL be ignored (no redirect, no flush).
REQ-028 halt_req = 1 in RUN, no redirect: next state HALT; IF/ID <= bubble; PC held.
REQ-029 halt_req with simultaneous valid redirect: redirect taken, HALT entered from the next cycle on which halt_req is still high.
REQ-030 HALT: PC, fetch_count frozen; if_id_valid = 0; halted = 1; exit only by reset.
REQ-031 halt_req, stall, pc_change ignored in IDLE.

Reset
REQ-032 On rst: PC = RESET_PC, state = IDLE, if_id_pc = 0, if_id_inst = 0, if_id_valid = 0, fetch_count = 0, halted = 0; flush_idex = 0 while rst high.
REQ-033 rst asserted mid-operation SHALL discard any pending redirect, stall or halt immediately (asynchronous).

Structure
REQ-034 Shared package cpu_pkg SHALL hold the state enum, pc_sel encodings (PCSEL_SEQ, PCSEL_RS, PCSEL_MEM) and instruction field positions (opcode 31:28, rd 27:22, rs 21:16, rt 15:10).
REQ-035 One sub-module SHALL be used: if_id_reg (IF/ID pipeline register with enable, bubble-insert, async reset); PC register and FSM live in fetch_stage.

Verification
REQ-036 Reset, then 4 cycles, imem_data = 32'hA000_0000+addr -> IDLE 1 cycle; IF/ID pc 0,1,2; fetch_count 3.
REQ-037 Stall high 2 cycles at PC = 5 -> PC stays 5, if_id outputs unchanged, fetch_count unchanged, resumes at 5.
REQ-038 pc_change = 1, pc_sel = 10, tgt_mem = 32'h40, stall = 1 same cycle -> flush_idex = 1, next PC = 32'h40, if_id_valid = 0, next fetch at 32'h40.
REQ-039 PC = 32'hFFFF_FFFF running -> next PC = 0, no stall or flag side effects.
REQ-040 halt_req = 1 at PC = 9 -> halted = 1, PC frozen at 9, if_id_valid = 0 for 10 cycles; rst -> PC = RESET_PC, state IDLE.
REQ-041 pc_change = 1, pc_sel = 11 -> no redirect, flush_idex = 0, sequential fetch continues.
